// File: rtl/cmp_event_counter.sv
// Windowed per-flag event counter fed by the 4-bit magnitude comparator.
// Optional macro CMP_CNT_SATURATE_EN: working counters saturate instead of wrap.
module cmp_event_counter #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             equal,
    input  logic             lesser,
    input  logic             greater,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] eq_total,
    output logic [CNT_W-1:0] lt_total,
    output logic [CNT_W-1:0] gt_total,
    output logic [CNT_W-1:0] idle_total,
    output logic [CNT_W-1:0] win_len,
    output logic             conflict
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] eq_cnt, lt_cnt, gt_cnt, idle_cnt, smp_cnt;
    logic [CNT_W-1:0] eq_nxt, lt_nxt, gt_nxt, idle_nxt, smp_nxt;
    logic             conf_cnt, conf_nxt;
    logic             accept, close, multi, none;

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
`ifdef CMP_CNT_SATURATE_EN
        if (en && (v != '1))
            return v + CNT_W'(1);
        return v;
`else
        return v + CNT_W'(en);
`endif
    endfunction

    assign accept = in_valid && in_ready;
    assign multi  = (equal & lesser) | (equal & greater) | (lesser & greater);
    assign none   = ~(equal | lesser | greater);

    // Next working values already include the sample accepted this cycle.
    assign eq_nxt   = bump(eq_cnt, accept & equal);
    assign lt_nxt   = bump(lt_cnt, accept & lesser);
    assign gt_nxt   = bump(gt_cnt, accept & greater);
    assign idle_nxt = bump(idle_cnt, accept & none);
    assign smp_nxt  = smp_cnt + CNT_W'(accept);
    assign conf_nxt = conf_cnt | (accept & multi);

    assign close = (accept && (smp_nxt == CNT_W'(WINDOW)))
                || ((state == ACCUM) && flush && (smp_nxt != '0));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (close)
                    state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCUM;
            eq_cnt     <= '0;
            lt_cnt     <= '0;
            gt_cnt     <= '0;
            idle_cnt   <= '0;
            smp_cnt    <= '0;
            conf_cnt   <= 1'b0;
            eq_total   <= '0;
            lt_total   <= '0;
            gt_total   <= '0;
            idle_total <= '0;
            win_len    <= '0;
            conflict   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (close) begin
                eq_total   <= eq_nxt;
                lt_total   <= lt_nxt;
                gt_total   <= gt_nxt;
                idle_total <= idle_nxt;
                win_len    <= smp_nxt;
                conflict   <= conf_nxt;
                eq_cnt     <= '0;
                lt_cnt     <= '0;
                gt_cnt     <= '0;
                idle_cnt   <= '0;
                smp_cnt    <= '0;
                conf_cnt   <= 1'b0;
            end else if (accept) begin
                eq_cnt   <= eq_nxt;
                lt_cnt   <= lt_nxt;
                gt_cnt   <= gt_nxt;
                idle_cnt <= idle_nxt;
                smp_cnt  <= smp_nxt;
                conf_cnt <= conf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cmp_event_counter.sv
// Directed bench: queue-based window model for the default instance,
// literal checks for a small CNT_W=2/WINDOW=3 instance.
module tb_cmp_event_counter;

    localparam int WINDOW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, in_ready, equal, lesser, greater, flush;
    logic       out_valid, out_ready, conflict;
    logic [7:0] eq_total, lt_total, gt_total, idle_total, win_len;

    logic       s_reset, s_in_valid, s_in_ready, s_flush;
    logic       s_out_valid, s_out_ready, s_conflict;
    logic [1:0] s_eq, s_lt, s_gt, s_idle, s_len;

    cmp_event_counter #(.CNT_W(8), .WINDOW(WINDOW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .equal(equal), .lesser(lesser), .greater(greater), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .eq_total(eq_total), .lt_total(lt_total), .gt_total(gt_total),
        .idle_total(idle_total), .win_len(win_len), .conflict(conflict)
    );

    cmp_event_counter #(.CNT_W(2), .WINDOW(3)) dut_s (
        .clk(clk), .reset(s_reset), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .equal(1'b1), .lesser(1'b0),
        .greater(1'b0), .flush(s_flush), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .eq_total(s_eq), .lt_total(s_lt),
        .gt_total(s_gt), .idle_total(s_idle), .win_len(s_len),
        .conflict(s_conflict)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: collect the window's samples, total them when it closes.
    logic [2:0] q[$];
    bit m_hold = 0;
    int m_eq = 0, m_lt = 0, m_gt = 0, m_idle = 0, m_len = 0;
    bit m_conf = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_hold = 0;
            m_eq = 0; m_lt = 0; m_gt = 0; m_idle = 0; m_len = 0;
            m_conf = 0;
        end else if (!m_hold) begin
            if (in_valid)
                q.push_back({equal, lesser, greater});
            if ((in_valid && q.size() == WINDOW)
                || (flush && q.size() > 0)) begin
                m_eq = 0; m_lt = 0; m_gt = 0; m_idle = 0; m_conf = 0;
                foreach (q[i]) begin
                    m_eq += int'(q[i][2]);
                    m_lt += int'(q[i][1]);
                    m_gt += int'(q[i][0]);
                    if ($countones(q[i]) == 0) m_idle++;
                    if ($countones(q[i]) > 1) m_conf = 1;
                end
                m_len = q.size();
                q.delete();
                m_hold = 1;
            end
        end else if (out_ready) begin
            m_hold = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(!m_hold));
            check("out_valid", 32'(out_valid), 32'(m_hold));
            check("eq_total", 32'(eq_total), m_eq);
            check("lt_total", 32'(lt_total), m_lt);
            check("gt_total", 32'(gt_total), m_gt);
            check("idle_total", 32'(idle_total), m_idle);
            check("win_len", 32'(win_len), m_len);
            check("conflict", 32'(conflict), 32'(m_conf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic e, input logic l, input logic g,
                        input logic fl);
        in_valid = 1'b1;
        equal = e; lesser = l; greater = g; flush = fl;
        step();
        in_valid = 1'b0; flush = 1'b0;
        equal = 1'b0; lesser = 1'b0; greater = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic s_send(input logic fl);
        s_in_valid = 1'b1;
        s_flush = fl;
        step();
        s_in_valid = 1'b0;
        s_flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        equal = 1'b0; lesser = 1'b0; greater = 1'b0;
        s_reset = 1'b1; s_in_valid = 1'b0; s_flush = 1'b0;
        s_out_ready = 1'b0;
        step(); step();
        reset = 1'b0; s_reset = 1'b0;
        chk_en = 1;
        check("rst in_ready", 32'(in_ready), 1);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst win_len", 32'(win_len), 0);

        // 16 x E
        for (int i = 0; i < 16; i++) send(1, 0, 0, 0);
        check("t1 out_valid", 32'(out_valid), 1);
        check("t1 eq_total", 32'(eq_total), 16);
        check("t1 win_len", 32'(win_len), 16);
        check("t1 conflict", 32'(conflict), 0);
        drain();
        check("t1 in_ready", 32'(in_ready), 1);
        check("t1 eq kept", 32'(eq_total), 16);

        // mixed: 5 E, 6 L, 4 G, 1 none
        for (int i = 0; i < 5; i++) send(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) send(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) send(0, 0, 1, 0);
        send(0, 0, 0, 0);
        check("t2 eq", 32'(eq_total), 5);
        check("t2 lt", 32'(lt_total), 6);
        check("t2 gt", 32'(gt_total), 4);
        check("t2 idle", 32'(idle_total), 1);
        drain();

        // one L=G conflict sample among 15 E
        for (int i = 0; i < 16; i++) begin
            if (i == 7) send(0, 1, 1, 0);
            else send(1, 0, 0, 0);
        end
        check("t3 eq", 32'(eq_total), 15);
        check("t3 lt", 32'(lt_total), 1);
        check("t3 gt", 32'(gt_total), 1);
        check("t3 conflict", 32'(conflict), 1);
        drain();

        // flush with the 3rd accept, then an empty flush
        send(0, 0, 1, 0);
        send(0, 0, 1, 0);
        send(0, 0, 1, 1);
        check("t4 out_valid", 32'(out_valid), 1);
        check("t4 gt", 32'(gt_total), 3);
        check("t4 win_len", 32'(win_len), 3);
        drain();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4 empty flush", 32'(out_valid), 0);
        step();

        // HOLD with stalled consumer and pushing producer
        for (int i = 0; i < 16; i++) send(0, 1, 0, 0);
        in_valid = 1'b1; equal = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5 in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0; equal = 1'b0;
        check("t5 lt", 32'(lt_total), 16);
        drain();
        check("t5 ready after", 32'(in_ready), 1);
        send(1, 0, 0, 1);
        check("t5 win_len", 32'(win_len), 1);
        drain();

        // small instance: CNT_W=2, WINDOW=3
        for (int i = 0; i < 3; i++) s_send(0);
        check("s eq", 32'(s_eq), 3);
        check("s len", 32'(s_len), 3);
        check("s out_valid", 32'(s_out_valid), 1);
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        s_send(0);
        s_send(0);
        s_reset = 1'b1;
        step();
        s_reset = 1'b0;
        check("s rst eq", 32'(s_eq), 0);
        check("s rst len", 32'(s_len), 0);
        check("s rst out_valid", 32'(s_out_valid), 0);
        check("s rst in_ready", 32'(s_in_ready), 1);
        s_send(1);
        check("s partial lost", 32'(s_len), 1);
        check("s eq after", 32'(s_eq), 1);
        check("s lt", 32'({s_lt, s_gt, s_idle, s_conflict}), 0);
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        step();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
